// File: rtl/lab2_proc_mem_port_arbiter_pkg.sv
// rtl/lab2_proc_mem_port_arbiter_pkg.sv - 4B memory message types and port-tag helper
package lab2_proc_mem_port_arbiter_pkg;

  localparam int req_bits  = 77;
  localparam int resp_bits = 47;
  localparam int tag_bit   = 7;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4b_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4b_t;

  // The top opaque bit is borrowed to carry the issuing port through memory.
  function automatic logic [7:0] tag_opaque(input logic [7:0] opaque, input logic port_id);
    return {port_id, opaque[tag_bit-1:0]};
  endfunction

endpackage

// File: rtl/lab2_proc_mem_port_arbiter_queue.sv
// rtl/lab2_proc_mem_port_arbiter_queue.sv - normal (non-bypass) circular response queue
module lab2_proc_mem_port_arbiter_queue #(
  parameter int p_depth = 2,
  parameter int p_width = 47
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_width-1:0] enq_msg,
  input  logic               enq_val,
  output logic               enq_rdy,
  output logic [p_width-1:0] deq_msg,
  output logic               deq_val,
  input  logic               deq_rdy
);

  localparam int aw = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int cw = $clog2(p_depth + 1);

  logic [p_width-1:0] entries [p_depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic [cw-1:0]      count;
  logic               enq;
  logic               deq;

  function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] ptr);
    return (ptr == aw'(p_depth - 1)) ? '0 : ptr + aw'(1);
  endfunction

  assign enq_rdy = (count != cw'(p_depth));
  assign deq_val = (count != '0);
  assign deq_msg = entries[rd_ptr];
  assign enq     = enq_val && enq_rdy;
  assign deq     = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr] <= enq_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (enq && !deq) begin
        count <= count + cw'(1);
      end else if (!enq && deq) begin
        count <= count - cw'(1);
      end
    end
  end

endmodule

// File: rtl/lab2_proc_rr_arb2.sv
// rtl/lab2_proc_rr_arb2.sv - two-way round-robin grant with a last-winner priority register
module lab2_proc_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] grant
);

  logic prio;

  // The winner drops to lowest priority: port 0 winning hands priority to port 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (xfer) begin
      prio <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req[prio]) begin
      grant[prio] = 1'b1;
    end else if (req[~prio]) begin
      grant[~prio] = 1'b1;
    end
  end

endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// rtl/lab2_proc_mem_port_arbiter.sv - merges imem/dmem request streams onto one memory port
module lab2_proc_mem_port_arbiter
  import lab2_proc_mem_port_arbiter_pkg::*;
#(
  parameter int p_max_inflight = 2,
  parameter int p_resp_q_depth = 2
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [req_bits-1:0]  imem_reqstream_msg,
  input  logic                 imem_reqstream_val,
  output logic                 imem_reqstream_rdy,
  output logic [resp_bits-1:0] imem_respstream_msg,
  output logic                 imem_respstream_val,
  input  logic                 imem_respstream_rdy,

  input  logic [req_bits-1:0]  dmem_reqstream_msg,
  input  logic                 dmem_reqstream_val,
  output logic                 dmem_reqstream_rdy,
  output logic [resp_bits-1:0] dmem_respstream_msg,
  output logic                 dmem_respstream_val,
  input  logic                 dmem_respstream_rdy,

  output logic [req_bits-1:0]  mem_reqstream_msg,
  output logic                 mem_reqstream_val,
  input  logic                 mem_reqstream_rdy,
  input  logic [resp_bits-1:0] mem_respstream_msg,
  input  logic                 mem_respstream_val,
  output logic                 mem_respstream_rdy
);

  localparam int cw = $clog2(p_max_inflight + 1);
  localparam logic [cw-1:0] max_cnt = cw'(p_max_inflight);

  logic [1:0]    req_val;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    req_xfer;
  logic [1:0]    resp_xfer;
  logic [1:0]    q_enq_rdy;
  logic [cw-1:0] inflight [2];

  mem_req_4b_t   sel_req;
  mem_resp_4b_t  mem_resp;
  mem_resp_4b_t  clean_resp;
  logic          resp_dest;

  assign req_val = {dmem_reqstream_val, imem_reqstream_val};

  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_val[i] && (inflight[i] < max_cnt);
    end
  end

  lab2_proc_rr_arb2 arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .xfer  (mem_reqstream_val && mem_reqstream_rdy),
    .grant (grant)
  );

  assign mem_reqstream_val  = |elig;
  assign imem_reqstream_rdy = grant[0] && mem_reqstream_rdy;
  assign dmem_reqstream_rdy = grant[1] && mem_reqstream_rdy;

  always_comb begin
    sel_req        = grant[1] ? mem_req_4b_t'(dmem_reqstream_msg)
                              : mem_req_4b_t'(imem_reqstream_msg);
    sel_req.opaque = tag_opaque(sel_req.opaque, grant[1]);
  end

  assign mem_reqstream_msg = sel_req;

  assign mem_resp  = mem_respstream_msg;
  assign resp_dest = mem_resp.opaque[tag_bit];

  always_comb begin
    clean_resp                 = mem_resp;
    clean_resp.opaque[tag_bit] = 1'b0;
  end

  // Ready follows the destination queue only, never the memory's val.
  assign mem_respstream_rdy = q_enq_rdy[resp_dest];

  lab2_proc_mem_port_arbiter_queue #(.p_depth(p_resp_q_depth), .p_width(resp_bits)) imem_resp_q (
    .clk     (clk),
    .reset   (reset),
    .enq_msg (clean_resp),
    .enq_val (mem_respstream_val && !resp_dest),
    .enq_rdy (q_enq_rdy[0]),
    .deq_msg (imem_respstream_msg),
    .deq_val (imem_respstream_val),
    .deq_rdy (imem_respstream_rdy)
  );

  lab2_proc_mem_port_arbiter_queue #(.p_depth(p_resp_q_depth), .p_width(resp_bits)) dmem_resp_q (
    .clk     (clk),
    .reset   (reset),
    .enq_msg (clean_resp),
    .enq_val (mem_respstream_val && resp_dest),
    .enq_rdy (q_enq_rdy[1]),
    .deq_msg (dmem_respstream_msg),
    .deq_val (dmem_respstream_val),
    .deq_rdy (dmem_respstream_rdy)
  );

  assign req_xfer  = {dmem_reqstream_val && dmem_reqstream_rdy,
                      imem_reqstream_val && imem_reqstream_rdy};
  assign resp_xfer = {dmem_respstream_val && dmem_respstream_rdy,
                      imem_respstream_val && imem_respstream_rdy};

  // A request counts as in flight until its response is handed to the processor.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight[0] <= '0;
      inflight[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_xfer[i] && !resp_xfer[i]) begin
          inflight[i] <= inflight[i] + cw'(1);
        end else if (!req_xfer[i] && resp_xfer[i]) begin
          inflight[i] <= inflight[i] - cw'(1);
        end
      end
    end
  end

  resp_for_idle_port: assert property (@(posedge clk) disable iff (reset)
    (mem_respstream_val && mem_respstream_rdy) |-> (inflight[resp_dest] != '0));

  inflight_fits_queue: assert property (@(posedge clk) p_max_inflight <= p_resp_q_depth);

endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// tb/tb_lab2_proc_mem_port_arbiter.sv - directed and randomized checks of the memory port arbiter
module tb_lab2_proc_mem_port_arbiter;

  localparam int P_MAX   = 2;
  localparam int P_DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [76:0] imem_reqstream_msg;
  logic        imem_reqstream_val;
  logic        imem_reqstream_rdy;
  logic [46:0] imem_respstream_msg;
  logic        imem_respstream_val;
  logic        imem_respstream_rdy;
  logic [76:0] dmem_reqstream_msg;
  logic        dmem_reqstream_val;
  logic        dmem_reqstream_rdy;
  logic [46:0] dmem_respstream_msg;
  logic        dmem_respstream_val;
  logic        dmem_respstream_rdy;
  logic [76:0] mem_reqstream_msg;
  logic        mem_reqstream_val;
  logic        mem_reqstream_rdy;
  logic [46:0] mem_respstream_msg;
  logic        mem_respstream_val;
  logic        mem_respstream_rdy;

  int checks;
  int errors;

  lab2_proc_mem_port_arbiter #(.p_max_inflight(P_MAX), .p_resp_q_depth(P_DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .imem_reqstream_msg  (imem_reqstream_msg),
    .imem_reqstream_val  (imem_reqstream_val),
    .imem_reqstream_rdy  (imem_reqstream_rdy),
    .imem_respstream_msg (imem_respstream_msg),
    .imem_respstream_val (imem_respstream_val),
    .imem_respstream_rdy (imem_respstream_rdy),
    .dmem_reqstream_msg  (dmem_reqstream_msg),
    .dmem_reqstream_val  (dmem_reqstream_val),
    .dmem_reqstream_rdy  (dmem_reqstream_rdy),
    .dmem_respstream_msg (dmem_respstream_msg),
    .dmem_respstream_val (dmem_respstream_val),
    .dmem_respstream_rdy (dmem_respstream_rdy),
    .mem_reqstream_msg   (mem_reqstream_msg),
    .mem_reqstream_val   (mem_reqstream_val),
    .mem_reqstream_rdy   (mem_reqstream_rdy),
    .mem_respstream_msg  (mem_respstream_msg),
    .mem_respstream_val  (mem_respstream_val),
    .mem_respstream_rdy  (mem_respstream_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request: type[76:74] opaque[73:66] addr[65:34] len[33:32] data[31:0]
  function automatic logic [76:0] mk_req(input logic [7:0] op, input logic [31:0] addr);
    return {3'd0, op, addr, 2'd0, 32'd0};
  endfunction

  // Response: type[46:44] opaque[43:36] test[35:34] len[33:32] data[31:0]
  function automatic logic [46:0] mk_resp(input logic [7:0] op, input logic [31:0] data);
    return {3'd0, op, 2'd0, 2'd0, data};
  endfunction

  function automatic logic [76:0] rand_req();
    logic [31:0] a, d, o;
    a = $urandom();
    d = $urandom();
    o = $urandom();
    return {o[2:0], o[15:8], a, o[17:16], d};
  endfunction

  function automatic logic [76:0] tag_req(input logic [76:0] m, input int port);
    logic [76:0] r;
    r = m;
    r[73] = port[0];
    return r;
  endfunction

  function automatic logic [46:0] resp_for(input logic [76:0] req);
    logic [31:0] d;
    d = $urandom();
    return {req[76:74], req[73:66], 2'b00, req[33:32], d};
  endfunction

  task automatic clear_inputs();
    imem_reqstream_msg  = '0;
    imem_reqstream_val  = 1'b0;
    imem_respstream_rdy = 1'b0;
    dmem_reqstream_msg  = '0;
    dmem_reqstream_val  = 1'b0;
    dmem_respstream_rdy = 1'b0;
    mem_reqstream_rdy   = 1'b0;
    mem_respstream_msg  = '0;
    mem_respstream_val  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL reset_mem_val: got %0b expected 0", mem_reqstream_val); end
    checks++; if (imem_respstream_val !== 1'b0) begin errors++; $display("FAIL reset_imem_resp_val: got %0b expected 0", imem_respstream_val); end
    checks++; if (dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL reset_dmem_resp_val: got %0b expected 0", dmem_respstream_val); end
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL reset_mem_resp_rdy_i: got %0b expected 1", mem_respstream_rdy); end
    mem_respstream_msg = mk_resp(8'h80, 32'd0);
    #1;
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL reset_mem_resp_rdy_d: got %0b expected 1", mem_respstream_rdy); end
    imem_reqstream_val = 1'b1;
    dmem_reqstream_val = 1'b1;
    mem_reqstream_rdy  = 1'b1;
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL reset_prio_imem_rdy: got %0b expected 1", imem_reqstream_rdy); end
    checks++; if (dmem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL reset_prio_dmem_rdy: got %0b expected 0", dmem_reqstream_rdy); end
    clear_inputs();
  endtask

  task automatic test_single_imem();
    logic [76:0] req;
    logic [46:0] resp;
    do_reset();
    req  = mk_req(8'h00, 32'h0000_0200);
    resp = mk_resp(8'h00, 32'hcafe_f00d);
    imem_reqstream_msg  = req;
    imem_reqstream_val  = 1'b1;
    mem_reqstream_rdy   = 1'b1;
    imem_respstream_rdy = 1'b1;
    dmem_respstream_rdy = 1'b1;
    #1;
    checks++; if (mem_reqstream_val !== 1'b1) begin errors++; $display("FAIL single_mem_val: got %0b expected 1", mem_reqstream_val); end
    checks++; if (mem_reqstream_msg !== req) begin errors++; $display("FAIL single_mem_msg: got %h expected %h", mem_reqstream_msg, req); end
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL single_imem_rdy: got %0b expected 1", imem_reqstream_rdy); end
    @(negedge clk);
    imem_reqstream_val = 1'b0;
    mem_respstream_msg = resp;
    mem_respstream_val = 1'b1;
    #1;
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL single_mem_resp_rdy: got %0b expected 1", mem_respstream_rdy); end
    checks++; if (imem_respstream_val !== 1'b0) begin errors++; $display("FAIL single_resp_early: got %0b expected 0", imem_respstream_val); end
    @(negedge clk);
    mem_respstream_val = 1'b0;
    #1;
    checks++; if (imem_respstream_val !== 1'b1) begin errors++; $display("FAIL single_resp_val: got %0b expected 1", imem_respstream_val); end
    checks++; if (imem_respstream_msg !== resp) begin errors++; $display("FAIL single_resp_msg: got %h expected %h", imem_respstream_msg, resp); end
    checks++; if (dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL single_dmem_resp_val: got %0b expected 0", dmem_respstream_val); end
    @(negedge clk);
    #1;
    checks++; if (imem_respstream_val !== 1'b0) begin errors++; $display("FAIL single_resp_drained: got %0b expected 0", imem_respstream_val); end
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [76:0] prev;
    logic [76:0] exp_msg;
    bit          have_prev;
    int          exp_port;
    do_reset();
    have_prev           = 1'b0;
    mem_reqstream_rdy   = 1'b1;
    imem_respstream_rdy = 1'b1;
    dmem_respstream_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      imem_reqstream_val = 1'b1;
      dmem_reqstream_val = 1'b1;
      imem_reqstream_msg = rand_req();
      dmem_reqstream_msg = rand_req();
      mem_respstream_val = have_prev;
      if (have_prev) mem_respstream_msg = resp_for(prev);
      #1;
      exp_port = k % 2;
      exp_msg  = tag_req((exp_port == 1) ? dmem_reqstream_msg : imem_reqstream_msg, exp_port);
      checks++; if (imem_reqstream_rdy !== (exp_port == 0)) begin errors++; $display("FAIL alt_imem_rdy[%0d]: got %0b expected %0b", k, imem_reqstream_rdy, exp_port == 0); end
      checks++; if (dmem_reqstream_rdy !== (exp_port == 1)) begin errors++; $display("FAIL alt_dmem_rdy[%0d]: got %0b expected %0b", k, dmem_reqstream_rdy, exp_port == 1); end
      checks++; if (mem_reqstream_msg !== exp_msg) begin errors++; $display("FAIL alt_mem_msg[%0d]: got %h expected %h", k, mem_reqstream_msg, exp_msg); end
      if (have_prev) begin
        checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL alt_mem_resp_rdy[%0d]: got %0b expected 1", k, mem_respstream_rdy); end
      end
      prev      = exp_msg;
      have_prev = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_inflight_limit();
    do_reset();
    mem_reqstream_rdy  = 1'b1;
    imem_reqstream_val = 1'b1;
    imem_reqstream_msg = mk_req(8'h01, 32'h100);
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL limit_i0_rdy: got %0b expected 1", imem_reqstream_rdy); end
    @(negedge clk);
    imem_reqstream_msg = mk_req(8'h02, 32'h104);
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL limit_i1_rdy: got %0b expected 1", imem_reqstream_rdy); end
    @(negedge clk);
    imem_reqstream_msg = mk_req(8'h03, 32'h108);
    dmem_reqstream_val = 1'b1;
    dmem_reqstream_msg = mk_req(8'h11, 32'h400);
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL limit_i2_stall: got %0b expected 0", imem_reqstream_rdy); end
    checks++; if (dmem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL limit_d0_rdy: got %0b expected 1", dmem_reqstream_rdy); end
    @(negedge clk);
    dmem_reqstream_msg = mk_req(8'h12, 32'h404);
    #1;
    checks++; if (dmem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL limit_d1_rdy: got %0b expected 1", dmem_reqstream_rdy); end
    checks++; if (imem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL limit_i2_still_stall: got %0b expected 0", imem_reqstream_rdy); end
    @(negedge clk);
    #1;
    checks++; if (mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL limit_both_full: got %0b expected 0", mem_reqstream_val); end
  endtask

  // Continues from the state test_inflight_limit leaves: two in flight per port.
  task automatic test_reset_midflight();
    logic [46:0] resp_i, resp_d;
    resp_i = mk_resp(8'h01, 32'h1111_0000);
    resp_d = mk_resp(8'h91, 32'h2222_0000);
    @(negedge clk);
    mem_respstream_msg  = resp_i;
    mem_respstream_val  = 1'b1;
    imem_respstream_rdy = 1'b1;
    dmem_respstream_rdy = 1'b0;
    #1;
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_resp_i_rdy: got %0b expected 1", mem_respstream_rdy); end
    @(negedge clk);
    mem_respstream_val = 1'b0;
    #1;
    checks++; if (imem_respstream_msg !== resp_i || imem_respstream_val !== 1'b1) begin errors++; $display("FAIL mid_resp_i_deliver: got val %0b msg %h expected val 1 msg %h", imem_respstream_val, imem_respstream_msg, resp_i); end
    @(negedge clk);
    mem_respstream_msg = resp_d;
    mem_respstream_val = 1'b1;
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_i2_after_free: got %0b expected 1", imem_reqstream_rdy); end
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_resp_d_rdy: got %0b expected 1", mem_respstream_rdy); end
    @(negedge clk);
    mem_respstream_val = 1'b0;
    #1;
    checks++; if (dmem_respstream_val !== 1'b1) begin errors++; $display("FAIL mid_resp_d_held: got %0b expected 1", dmem_respstream_val); end
    checks++; if (mem_reqstream_val !== 1'b0) begin errors++; $display("FAIL mid_all_full: got %0b expected 0", mem_reqstream_val); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_respstream_val !== 1'b0) begin errors++; $display("FAIL mid_rst_imem_resp_val: got %0b expected 0", imem_respstream_val); end
    checks++; if (dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL mid_rst_dmem_resp_val: got %0b expected 0", dmem_respstream_val); end
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_prio_imem: got %0b expected 1", imem_reqstream_rdy); end
    checks++; if (dmem_reqstream_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_prio_dmem: got %0b expected 0", dmem_reqstream_rdy); end
    @(negedge clk);
    #1;
    checks++; if (dmem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_dmem_count_cleared: got %0b expected 1", dmem_reqstream_rdy); end
    clear_inputs();
  endtask

  task automatic test_out_of_order();
    logic [46:0] resp_i, resp_d, clean_d;
    do_reset();
    resp_i  = mk_resp(8'h21, 32'haaaa_5555);
    resp_d  = mk_resp(8'ha2, 32'h5555_aaaa);
    clean_d = mk_resp(8'h22, 32'h5555_aaaa);
    mem_reqstream_rdy  = 1'b1;
    imem_reqstream_val = 1'b1;
    imem_reqstream_msg = mk_req(8'h21, 32'h200);
    #1;
    checks++; if (imem_reqstream_rdy !== 1'b1) begin errors++; $display("FAIL ooo_imem_rdy: got %0b expected 1", imem_reqstream_rdy); end
    @(negedge clk);
    imem_reqstream_val = 1'b0;
    dmem_reqstream_val = 1'b1;
    dmem_reqstream_msg = mk_req(8'h22, 32'h600);
    #1;
    checks++; if (dmem_reqstream_msg !== 77'(0) && mem_reqstream_msg[73:66] !== 8'ha2) begin errors++; $display("FAIL ooo_dmem_tag: got %h expected a2", mem_reqstream_msg[73:66]); end
    @(negedge clk);
    dmem_reqstream_val  = 1'b0;
    mem_respstream_msg  = resp_d;
    mem_respstream_val  = 1'b1;
    imem_respstream_rdy = 1'b1;
    dmem_respstream_rdy = 1'b0;
    #1;
    checks++; if (mem_respstream_rdy !== 1'b1) begin errors++; $display("FAIL ooo_resp_d_rdy: got %0b expected 1", mem_respstream_rdy); end
    @(negedge clk);
    mem_respstream_msg = resp_i;
    #1;
    checks++; if (dmem_respstream_msg !== clean_d || dmem_respstream_val !== 1'b1) begin errors++; $display("FAIL ooo_d_queued: got val %0b msg %h expected val 1 msg %h", dmem_respstream_val, dmem_respstream_msg, clean_d); end
    checks++; if (imem_respstream_val !== 1'b0) begin errors++; $display("FAIL ooo_i_not_yet: got %0b expected 0", imem_respstream_val); end
    @(negedge clk);
    mem_respstream_val = 1'b0;
    #1;
    checks++; if (imem_respstream_msg !== resp_i || imem_respstream_val !== 1'b1) begin errors++; $display("FAIL ooo_i_delivered: got val %0b msg %h expected val 1 msg %h", imem_respstream_val, imem_respstream_msg, resp_i); end
    checks++; if (dmem_respstream_val !== 1'b1) begin errors++; $display("FAIL ooo_d_still_held: got %0b expected 1", dmem_respstream_val); end
    @(negedge clk);
    dmem_respstream_rdy = 1'b1;
    #1;
    checks++; if (dmem_respstream_val !== 1'b1 || imem_respstream_val !== 1'b0) begin errors++; $display("FAIL ooo_d_release: got dval %0b ival %0b expected dval 1 ival 0", dmem_respstream_val, imem_respstream_val); end
    @(negedge clk);
    #1;
    checks++; if (dmem_respstream_val !== 1'b0) begin errors++; $display("FAIL ooo_d_drained: got %0b expected 0", dmem_respstream_val); end
    clear_inputs();
  endtask

  // Scoreboard model: per-port counts, last-winner priority, and FIFOs of expected responses.
  task automatic test_random();
    logic [76:0] pend[$];
    logic [46:0] rq0[$];
    logic [46:0] rq1[$];
    logic [76:0] src[2];
    logic [76:0] exp_req;
    logic [46:0] resp;
    int          infl[2];
    bit          elig[2];
    bit          prio;
    bit          dest;
    bit          exp_mrdy;
    int          g;
    int          pick;
    do_reset();
    infl[0] = 0;
    infl[1] = 0;
    prio    = 1'b0;
    exp_req = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_reqstream_val  = ($urandom_range(0, 3) != 0);
      dmem_reqstream_val  = ($urandom_range(0, 3) != 0);
      imem_reqstream_msg  = rand_req();
      dmem_reqstream_msg  = rand_req();
      mem_reqstream_rdy   = ($urandom_range(0, 3) != 0);
      imem_respstream_rdy = ($urandom_range(0, 2) != 0);
      dmem_respstream_rdy = ($urandom_range(0, 2) != 0);
      mem_respstream_val  = 1'b0;
      mem_respstream_msg  = '0;
      pick = -1;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, pend.size() - 1);
        mem_respstream_msg = resp_for(pend[pick]);
        mem_respstream_val = 1'b1;
      end
      #1;
      src[0]  = imem_reqstream_msg;
      src[1]  = dmem_reqstream_msg;
      elig[0] = imem_reqstream_val && (infl[0] < P_MAX);
      elig[1] = dmem_reqstream_val && (infl[1] < P_MAX);
      g = -1;
      if (elig[prio]) g = int'(prio);
      else if (elig[!prio]) g = int'(!prio);
      checks++; if (mem_reqstream_val !== (g >= 0)) begin errors++; $display("FAIL rnd_mem_val[%0d]: got %0b expected %0b", cyc, mem_reqstream_val, g >= 0); end
      checks++; if (imem_reqstream_rdy !== (g == 0 && mem_reqstream_rdy)) begin errors++; $display("FAIL rnd_imem_rdy[%0d]: got %0b expected %0b", cyc, imem_reqstream_rdy, g == 0 && mem_reqstream_rdy); end
      checks++; if (dmem_reqstream_rdy !== (g == 1 && mem_reqstream_rdy)) begin errors++; $display("FAIL rnd_dmem_rdy[%0d]: got %0b expected %0b", cyc, dmem_reqstream_rdy, g == 1 && mem_reqstream_rdy); end
      if (g >= 0) begin
        exp_req = tag_req(src[g], g);
        checks++; if (mem_reqstream_msg !== exp_req) begin errors++; $display("FAIL rnd_mem_msg[%0d]: got %h expected %h", cyc, mem_reqstream_msg, exp_req); end
      end
      dest     = mem_respstream_msg[43];
      exp_mrdy = dest ? (rq1.size() < P_DEPTH) : (rq0.size() < P_DEPTH);
      checks++; if (mem_respstream_rdy !== exp_mrdy) begin errors++; $display("FAIL rnd_mem_resp_rdy[%0d]: got %0b expected %0b", cyc, mem_respstream_rdy, exp_mrdy); end
      checks++; if (imem_respstream_val !== (rq0.size() > 0)) begin errors++; $display("FAIL rnd_imem_resp_val[%0d]: got %0b expected %0b", cyc, imem_respstream_val, rq0.size() > 0); end
      checks++; if (dmem_respstream_val !== (rq1.size() > 0)) begin errors++; $display("FAIL rnd_dmem_resp_val[%0d]: got %0b expected %0b", cyc, dmem_respstream_val, rq1.size() > 0); end
      if (rq0.size() > 0) begin
        checks++; if (imem_respstream_msg !== rq0[0]) begin errors++; $display("FAIL rnd_imem_resp_msg[%0d]: got %h expected %h", cyc, imem_respstream_msg, rq0[0]); end
      end
      if (rq1.size() > 0) begin
        checks++; if (dmem_respstream_msg !== rq1[0]) begin errors++; $display("FAIL rnd_dmem_resp_msg[%0d]: got %h expected %h", cyc, dmem_respstream_msg, rq1[0]); end
      end
      if (g >= 0 && mem_reqstream_rdy) begin
        pend.push_back(exp_req);
        infl[g]++;
        prio = (g == 0);
      end
      if (rq0.size() > 0 && imem_respstream_rdy) begin
        rq0.delete(0);
        infl[0]--;
      end
      if (rq1.size() > 0 && dmem_respstream_rdy) begin
        rq1.delete(0);
        infl[1]--;
      end
      if (pick >= 0 && exp_mrdy) begin
        resp     = mem_respstream_msg;
        resp[43] = 1'b0;
        if (dest) rq1.push_back(resp);
        else rq0.push_back(resp);
        pend.delete(pick);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_single_imem();
    test_alternate();
    test_inflight_limit();
    test_reset_midflight();
    test_out_of_order();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
